device_axi_bridge: RTL

DEVICE_AXI_BRIDGE -- requirements
Module: device_axi_bridge

---
 rtl/device_axi_bridge.sv | 104 ++++++++++
 1 files changed

// File: rtl/device_axi_bridge.sv
// device_axi_bridge: single-outstanding processor-request to AXI4-Lite master bridge.
// Ports: clk/reset (sync, active-high); device_* request side (addr, read/write level
// enables, write data, core id in; read data, ack, error, busy, response core id out);
// m_* AXI4-Lite master channels AW, W, B, AR, R with 32-bit address and data.
module device_axi_bridge #(
  parameter int NUM_CORES = 16,
  parameter logic [3:0] WSTRB_ALL = 4'hF,
  localparam int CIDW = $clog2(NUM_CORES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     device_addr,
  input  logic            device_read_en,
  input  logic            device_write_en,
  input  logic [31:0]     device_data_out,
  input  logic [CIDW-1:0] device_core_id,
  output logic [31:0]     device_data_in,
  output logic            device_ack,
  output logic            device_error,
  output logic            device_busy,
  output logic [CIDW-1:0] device_resp_core_id,
  output logic [31:0]     m_awaddr,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [31:0]     m_wdata,
  output logic [3:0]      m_wstrb,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  logic [1:0]      m_bresp,
  input  logic            m_bvalid,
  output logic            m_bready,
  output logic [31:0]     m_araddr,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rvalid,
  output logic            m_rready
);
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  state_t state, nxt;
  logic [31:0] addr_q, wdata_q;
  logic [CIDW-1:0] id_q;
  logic err_q, req, aligned;
  assign req     = device_write_en | device_read_en;
  assign aligned = device_addr[1:0] == 2'b00;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req) nxt = !aligned ? DONE : device_write_en ? WR : RD_ADDR;
      // AW and W may complete in either order; leave once neither is still pending.
      WR:      if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) nxt = WR_RESP;
      WR_RESP: if (m_bvalid) nxt = DONE;
      RD_ADDR: if (m_arready) nxt = RD_DATA;
      RD_DATA: if (m_rvalid) nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      m_awvalid      <= 1'b0;
      m_wvalid       <= 1'b0;
      m_arvalid      <= 1'b0;
      err_q          <= 1'b0;
      id_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      device_data_in <= '0;
    end else if (state == IDLE) begin
      if (req) begin
        addr_q    <= device_addr;
        wdata_q   <= device_data_out;
        id_q      <= device_core_id;
        err_q     <= !aligned;
        m_awvalid <= aligned & device_write_en;
        m_wvalid  <= aligned & device_write_en;
        m_arvalid <= aligned & !device_write_en;
      end
    end else begin
      if (m_awvalid && m_awready) m_awvalid <= 1'b0;
      if (m_wvalid && m_wready) m_wvalid <= 1'b0;
      if (m_arvalid && m_arready) m_arvalid <= 1'b0;
      if (state == WR_RESP && m_bvalid) err_q <= m_bresp != 2'b00;
      // Read data is loaded even on an RRESP error so the processor sees what came back.
      if (state == RD_DATA && m_rvalid) begin
        err_q          <= m_rresp != 2'b00;
        device_data_in <= m_rdata;
      end
    end
  end
  assign m_awaddr            = addr_q;
  assign m_araddr            = addr_q;
  assign m_wdata             = wdata_q;
  assign m_wstrb             = WSTRB_ALL;
  assign m_bready            = state == WR_RESP;
  assign m_rready            = state == RD_DATA;
  assign device_ack          = state == DONE;
  assign device_busy         = state != IDLE;
  assign device_error        = device_ack & err_q;
  assign device_resp_core_id = device_ack ? id_q : '0;
endmodule
